// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the writeback stage: load funct3 encodings, the
// writeback FSM state encoding, default datapath widths and a helper that
// flags misaligned load addresses.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // Load type encodings carried on funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

  // Byte loads are always aligned; halfwords need bit 0 clear; words (and the
  // reserved encodings, which behave as words) need both low bits clear.
  function automatic logic load_is_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// Bundles the three buses the writeback stage touches:
//   - execute handshake: ex_valid/ex_ready plus the retiring instruction fields
//   - data memory return: mem_rvalid/mem_rdata
//   - register file write port: wrt_en/oprd/wrt_data
// Modports:
//   master - the environment around the stage (execute, memory, regfile side)
//   slave  - the writeback stage itself
// ---------------------------------------------------------------------------
interface wb_stage_if
  import rv32i_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
);

  logic              ex_valid;
  logic              ex_ready;
  logic              ex_wb_en;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_result;
  logic [2:0]        ex_funct3;
  logic [1:0]        ex_addr_lo;

  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              wrt_en;
  logic [REG_AW-1:0] oprd;
  logic [XLEN-1:0]   wrt_data;

  modport master (
    output ex_valid, ex_wb_en, ex_is_load, ex_rd, ex_result, ex_funct3,
           ex_addr_lo, mem_rvalid, mem_rdata,
    input  ex_ready, wrt_en, oprd, wrt_data
  );

  modport slave (
    input  ex_valid, ex_wb_en, ex_is_load, ex_rd, ex_result, ex_funct3,
           ex_addr_lo, mem_rvalid, mem_rdata,
    output ex_ready, wrt_en, oprd, wrt_data
  );

endinterface

// File: rtl/load_ext.sv
// ---------------------------------------------------------------------------
// load_ext
// Combinational load data formatter: picks the byte/halfword addressed by
// addr_lo out of an aligned memory word and sign- or zero-extends it.
// Ports:
//   funct3  in  3     load type (LB/LH/LW/LBU/LHU; reserved codes act as LW)
//   addr_lo in  2     load address bits [1:0]
//   rdata   in  XLEN  aligned word from data memory
//   ext     out XLEN  value to write to the register file
// ---------------------------------------------------------------------------
module load_ext
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = rdata[16*gi +: 16];
    end
  endgenerate

  // Halfword lane is chosen by addr_lo[1] alone; alignment is enforced upstream
  assign sel_byte = byte_lane[addr_lo];
  assign sel_half = half_lane[addr_lo[1]];

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH:   ext = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, sel_half};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Writeback stage driving the register file write port. ALU results are
// written one cycle after acceptance; loads park in WAIT_LOAD until memory
// returns data, which is then formatted by load_ext and written.
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   bus             slave modport of wb_stage_if (execute handshake,
//                        memory return, register file write port)
//   pend_valid      out  a load is outstanding
//   pend_rd         out  destination of the outstanding load
//   load_misaligned out  one-cycle pulse for a rejected misaligned load
//   wb_count        out  number of register writes performed (wraps)
// All outputs except bus.ex_ready are registered.
// ---------------------------------------------------------------------------
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.slave         bus,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd,
  output logic              load_misaligned,
  output logic [CNT_W-1:0]  wb_count
);

  wb_state_t         state_reg, state_next;
  logic              wrt_en_reg, wrt_en_next;
  logic [REG_AW-1:0] oprd_reg, oprd_next;
  logic [XLEN-1:0]   wrt_data_reg, wrt_data_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [REG_AW-1:0] pend_rd_reg, pend_rd_next;
  logic              misal_reg, misal_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [2:0]        f3_reg, f3_next;
  logic [1:0]        lo_reg, lo_next;
  logic              wb_en_reg, wb_en_next;

  logic              accept;
  logic [XLEN-1:0]   ext_data;

  assign bus.ex_ready = (state_reg == WB_IDLE);
  assign accept       = bus.ex_valid && bus.ex_ready;

  // Formatting uses the funct3/addr_lo captured at acceptance, since execute
  // has moved on by the time memory answers.
  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3  (f3_reg),
    .addr_lo (lo_reg),
    .rdata   (bus.mem_rdata),
    .ext     (ext_data)
  );

  always_comb begin
    state_next      = state_reg;
    wrt_en_next     = 1'b0;
    oprd_next       = oprd_reg;
    wrt_data_next   = wrt_data_reg;
    pend_valid_next = pend_valid_reg;
    pend_rd_next    = pend_rd_reg;
    misal_next      = 1'b0;
    f3_next         = f3_reg;
    lo_next         = lo_reg;
    wb_en_next      = wb_en_reg;

    case (state_reg)
      WB_IDLE: begin
        // mem_rvalid is deliberately not looked at here
        if (accept) begin
          if (!bus.ex_is_load) begin
            wrt_en_next   = bus.ex_wb_en && (bus.ex_rd != '0);
            oprd_next     = bus.ex_rd;
            wrt_data_next = bus.ex_result;
          end else if (load_is_misaligned(bus.ex_funct3, bus.ex_addr_lo)) begin
            misal_next = 1'b1;
          end else begin
            f3_next         = bus.ex_funct3;
            lo_next         = bus.ex_addr_lo;
            wb_en_next      = bus.ex_wb_en;
            pend_valid_next = 1'b1;
            pend_rd_next    = bus.ex_rd;
            state_next      = WB_WAIT_LOAD;
          end
        end
      end

      WB_WAIT_LOAD: begin
        if (bus.mem_rvalid) begin
          // pend_rd_reg doubles as the captured load destination
          wrt_en_next     = wb_en_reg && (pend_rd_reg != '0);
          oprd_next       = pend_rd_reg;
          wrt_data_next   = ext_data;
          pend_valid_next = 1'b0;
          state_next      = WB_IDLE;
        end
      end

      default: state_next = WB_IDLE;
    endcase

    // Counter moves on the same edge that raises wrt_en
    count_next = count_reg + CNT_W'(wrt_en_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= WB_IDLE;
      wrt_en_reg     <= 1'b0;
      oprd_reg       <= '0;
      wrt_data_reg   <= '0;
      pend_valid_reg <= 1'b0;
      pend_rd_reg    <= '0;
      misal_reg      <= 1'b0;
      count_reg      <= '0;
      f3_reg         <= '0;
      lo_reg         <= '0;
      wb_en_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wrt_en_reg     <= wrt_en_next;
      oprd_reg       <= oprd_next;
      wrt_data_reg   <= wrt_data_next;
      pend_valid_reg <= pend_valid_next;
      pend_rd_reg    <= pend_rd_next;
      misal_reg      <= misal_next;
      count_reg      <= count_next;
      f3_reg         <= f3_next;
      lo_reg         <= lo_next;
      wb_en_reg      <= wb_en_next;
    end
  end

  assign bus.wrt_en      = wrt_en_reg;
  assign bus.oprd        = oprd_reg;
  assign bus.wrt_data    = wrt_data_reg;
  assign pend_valid      = pend_valid_reg;
  assign pend_rd         = pend_rd_reg;
  assign load_misaligned = misal_reg;
  assign wb_count        = count_reg;

endmodule
